// File: rtl/fifo_drain_reader_if.sv
// FIFO read port plus the outgoing valid/ready stream of the drain reader.
// The master side is the reader and the slave side is the FIFO/consumer environment.
interface fifo_drain_reader_if #(
    parameter int DWIDTH = 16
);
    logic              fifo_rd_en;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_empty;
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_drain_reader.sv
// Pops exactly len words from a 1-cycle-latency FIFO and replays them on a
// valid/ready stream through a 2-entry skid buffer, pulsing done at the end.
module fifo_drain_reader #(
    parameter int DWIDTH = 16,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] rd_count_o,
    fifo_drain_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  rd_count_q;
    logic              done_q;
    logic              inflight_q;
    logic [1:0]        occ_q, occ_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] tail_q, tail_d;

    logic              hs;
    logic              rd_en;
    logic [1:0]        load;
    logic [LEN_W-1:0]  issued_inc;
    logic [LEN_W-1:0]  rd_count_inc;

    assign hs           = (occ_q != 2'd0) && bus.m_ready;
    assign load         = occ_q + {1'b0, inflight_q};
    assign issued_inc   = issued_q + ONE;
    assign rd_count_inc = rd_count_q + ONE;

    // Held words (buffer + in flight) may never exceed two, counting the word leaving this edge.
    always_comb begin
        rd_en = 1'b0;
        if ((state_q == READ) && !bus.fifo_empty && (issued_q < len_q)) begin
            rd_en = (load < 2'd2) || ((load == 2'd2) && hs);
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({inflight_q, hs})
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) head_d = bus.fifo_dout;
                else               tail_d = bus.fifo_dout;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = bus.fifo_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.fifo_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            rd_count_q <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= rd_en;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            done_q     <= 1'b0;
            if (hs) rd_count_q <= rd_count_inc;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            len_q      <= len_i;
                            issued_q   <= '0;
                            rd_count_q <= '0;
                            state_q    <= READ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_en) begin
                        issued_q <= issued_inc;
                        if (issued_inc == len_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && (rd_count_inc == len_q)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign rd_count_o     = rd_count_q;
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = head_q;

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Bench for fifo_drain_reader: a queue-based FIFO model feeds the reader, and a
// transfer-level model predicts stream contents, flags and pop legality each cycle.
module tb_fifo_drain_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_r;
    logic [7:0] len_r;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rd_count_o;

    fifo_drain_reader_if #(.DWIDTH(16)) dif ();

    fifo_drain_reader #(.DWIDTH(16), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_r),
        .len_i      (len_r),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_count_o (rd_count_o),
        .bus        (dif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fq[$];
    logic [15:0] exp_words[$];

    bit          m_busy, m_done, prev_rd, stall_prev;
    int          m_len, m_cnt, m_iss, pops, hs_cnt;
    logic [15:0] stall_data;

    int cyc, pat, rdy_mode;
    int first_rd, last_rd, first_v, last_v, done_cnt, done_cyc;
    bit busy_seen;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; prev_rd = 0; stall_prev = 0;
        m_len = 0; m_cnt = 0; m_iss = 0; pops = 0; hs_cnt = 0;
        fq.delete();
        exp_words.delete();
        dif.fifo_empty = 1'b1;
    endtask

    task automatic clear_stats();
        first_rd = -1; last_rd = -1; first_v = -1; last_v = -1;
        done_cnt = 0; done_cyc = -1; busy_seen = 0;
    endtask

    task automatic push(logic [15:0] w);
        fq.push_back(w);
        exp_words.push_back(w);
        dif.fifo_empty = 1'b0;
    endtask

    // Expectations come from word accounting: popped-but-not-accepted words, minus the one still in flight.
    task automatic monitor();
        logic        e_valid, e_hs, e_rd;
        bit          n_done;
        int          held, landed;
        logic [15:0] exp_head;
        held     = pops - hs_cnt;
        landed   = held - (prev_rd ? 1 : 0);
        e_valid  = !rst && (landed > 0);
        e_hs     = e_valid && dif.m_ready;
        e_rd     = !rst && m_busy && (m_iss < m_len) && !dif.fifo_empty && ((held - (e_hs ? 1 : 0)) < 2);
        exp_head = (exp_words.size() != 0) ? exp_words[0] : 16'hdead;

        check("busy", 32'(busy_o), 32'(m_busy));
        check("done", 32'(done_o), 32'(m_done));
        check("rd_count", 32'(rd_count_o), 32'(m_cnt));
        check("m_valid", 32'(dif.m_valid), 32'(e_valid));
        check("fifo_rd_en", 32'(dif.fifo_rd_en), 32'(e_rd));
        if (e_valid) check("m_data", 32'(dif.m_data), 32'(exp_head));
        if (stall_prev) check("m_data_stable", 32'(dif.m_data), 32'(stall_data));

        if (dif.fifo_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (dif.m_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o) busy_seen = 1;

        stall_prev = e_valid && !dif.m_ready;
        stall_data = dif.m_data;
        if (!rst) begin
            if (e_hs) begin
                void'(exp_words.pop_front());
                hs_cnt++;
            end
            if (e_rd) begin
                pops++;
                m_iss++;
            end
            prev_rd = e_rd;
            n_done  = 0;
            if (!m_busy && start_r) begin
                if (len_r != 8'd0) begin
                    m_busy = 1; m_len = int'(len_r); m_cnt = 0; m_iss = 0;
                end else begin
                    n_done = 1;
                end
            end else if (m_busy && e_hs) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_busy = 0;
                    n_done = 1;
                end
            end
            m_done = n_done;
        end
    endtask

    // Check mid-cycle, then let the FIFO answer a pop right after the edge.
    task automatic cycle();
        logic pop_req;
        @(negedge clk);
        pop_req = dif.fifo_rd_en;
        monitor();
        @(posedge clk);
        #1;
        if (pop_req && fq.size() != 0) dif.fifo_dout = fq.pop_front();
        dif.fifo_empty = (fq.size() == 0);
        cyc++;
        pat++;
        case (rdy_mode)
            0:       dif.m_ready = 1'b1;
            1:       dif.m_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
            default: dif.m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_idle(int max_cyc, string tag);
        int n;
        n = 0;
        while ((m_busy || m_done) && n < max_cyc) begin
            cycle();
            n++;
        end
        check(tag, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic begin_xfer(int n);
        clear_stats();
        start_r = 1'b1;
        len_r   = 8'(n);
        cyc     = 0;
        cycle();
        start_r = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, to_push, l;
        rst = 1'b1; start_r = 1'b0; len_r = 8'd0;
        dif.fifo_dout = 16'h0; dif.fifo_empty = 1'b1; dif.m_ready = 1'b1;
        rdy_mode = 0; pat = 0; cyc = 0;
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rd_count", 32'(rd_count_o), 32'd0);
        check("rst_m_valid", 32'(dif.m_valid), 32'd0);
        check("rst_m_data", 32'(dif.m_data), 32'd0);
        check("rst_rd_en", 32'(dif.fifo_rd_en), 32'd0);
        rst = 1'b0;
        cycle();

        // Straight 8-word drain with the consumer always ready.
        for (int i = 1; i <= 8; i++) push(16'(16'h1111 * i));
        begin_xfer(8);
        run_idle(40, "t1_timeout");
        check("t1_first_rd", first_rd, 1);
        check("t1_last_rd", last_rd, 8);
        check("t1_first_valid", first_v, 3);
        check("t1_last_valid", last_v, 10);
        check("t1_done_cycle", done_cyc, 11);
        check("t1_done_count", done_cnt, 1);
        check("t1_rd_count", 32'(rd_count_o), 32'd8);
        check("t1_all_out", exp_words.size(), 0);

        // Consumer ready pattern 1,0,0,1.
        rdy_mode = 1; pat = 0;
        for (int i = 1; i <= 8; i++) push(16'(16'h1111 * i));
        begin_xfer(8);
        run_idle(80, "t2_timeout");
        check("t2_done_count", done_cnt, 1);
        check("t2_all_out", exp_words.size(), 0);
        check("t2_rd_count", 32'(rd_count_o), 32'd8);

        // FIFO starves after 3 words, refilled 5 cycles after start.
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) push(16'(16'ha000 + i));
        begin_xfer(6);
        repeat (4) cycle();
        for (int i = 3; i < 6; i++) push(16'(16'ha000 + i));
        run_idle(60, "t3_timeout");
        check("t3_done_count", done_cnt, 1);
        check("t3_all_out", exp_words.size(), 0);
        check("t3_rd_count", 32'(rd_count_o), 32'd6);

        // Zero-length start.
        begin_xfer(0);
        repeat (3) cycle();
        check("t4_done_cycle", done_cyc, 1);
        check("t4_done_count", done_cnt, 1);
        check("t4_busy_seen", 32'(busy_seen), 32'd0);
        check("t4_no_rd", first_rd, -1);
        check("t4_no_valid", first_v, -1);

        // Start while busy is ignored; start in the done cycle is accepted.
        for (int i = 0; i < 8; i++) push(16'(16'hb000 + i));
        for (int i = 0; i < 3; i++) push(16'(16'hc000 + i));
        begin_xfer(8);
        repeat (3) cycle();
        start_r = 1'b1; len_r = 8'd4;
        cycle();
        start_r = 1'b0;
        n = 0;
        while (!m_done && n < 60) begin
            cycle();
            n++;
        end
        check("t5_reach_done", 32'(n < 60), 32'd1);
        check("t5_done_now", 32'(done_o), 32'd1);
        start_r = 1'b1; len_r = 8'd3;
        cycle();
        start_r = 1'b0;
        check("t5_rd_count_clear", 32'(rd_count_o), 32'd0);
        check("t5_busy_again", 32'(busy_o), 32'd1);
        run_idle(40, "t5_timeout");
        check("t5_done_count", done_cnt, 2);
        check("t5_all_out", exp_words.size(), 0);
        check("t5_rd_count", 32'(rd_count_o), 32'd3);

        // Asynchronous reset in the middle of a transfer.
        for (int i = 0; i < 8; i++) push(16'(16'hd000 + i));
        begin_xfer(8);
        repeat (4) cycle();
        #2;
        check("t6_pre_valid", 32'(dif.m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_valid_drop", 32'(dif.m_valid), 32'd0);
        check("t6_busy_drop", 32'(busy_o), 32'd0);
        check("t6_rd_en_drop", 32'(dif.fifo_rd_en), 32'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) push(16'($urandom));
        begin_xfer(10);
        run_idle(200, "t6_timeout");
        check("t6_done_count", done_cnt, 1);
        check("t6_all_out", exp_words.size(), 0);

        // Random lengths, random ready, words trickling into the FIFO.
        for (int t = 0; t < 4; t++) begin
            l = int'($urandom_range(1, 24));
            to_push = l - int'($urandom_range(0, l));
            for (int i = 0; i < l - to_push; i++) push(16'($urandom));
            begin_xfer(l);
            n = 0;
            while ((m_busy || m_done) && n < 500) begin
                if (to_push > 0 && $urandom_range(0, 2) == 0) begin
                    push(16'($urandom));
                    to_push--;
                end
                cycle();
                n++;
            end
            check("t7_timeout", 32'(n < 500), 32'd1);
            check("t7_done_count", done_cnt, 1);
            check("t7_all_out", exp_words.size(), 0);
            check("t7_rd_count", 32'(rd_count_o), 32'(l));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
